// File: rtl/bsg_logic_pkg.sv
// rtl/bsg_logic_pkg.sv - opcode enum and bitwise op helper for the shared logic unit
package bsg_logic_pkg;

  typedef enum logic [1:0] {
    e_nor = 2'd0,
    e_and = 2'd1,
    e_or  = 2'd2,
    e_xor = 2'd3
  } bsg_logic_op_e;

  // Operates on the widest supported operand; callers zero-extend and truncate.
  localparam int bsg_logic_max_width_gp = 64;

  function automatic logic [bsg_logic_max_width_gp-1:0] bsg_logic_apply
    (input bsg_logic_op_e op,
     input logic [bsg_logic_max_width_gp-1:0] a,
     input logic [bsg_logic_max_width_gp-1:0] b);
    unique case (op)
      e_nor:   return ~(a | b);
      e_and:   return a & b;
      e_or:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/bsg_logic_rr_sched_if.sv
// rtl/bsg_logic_rr_sched_if.sv - requester and result handshake bundle of the scheduler
interface bsg_logic_rr_sched_if
  #(parameter int width_p       = 16,
    parameter int num_req_p     = 4,
    parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1);

  logic [num_req_p-1:0]         v_i;
  logic [num_req_p*width_p-1:0] a_i;
  logic [num_req_p*width_p-1:0] b_i;
  logic [num_req_p*2-1:0]       op_i;
  logic [num_req_p-1:0]         yumi_o;
  logic                         v_o;
  logic [width_p-1:0]           data_o;
  logic [lg_num_req_lp-1:0]     tag_o;
  logic                         yumi_i;

  modport master (output v_i, a_i, b_i, op_i, yumi_i,
                  input  yumi_o, v_o, data_o, tag_o);

  modport slave  (input  v_i, a_i, b_i, op_i, yumi_i,
                  output yumi_o, v_o, data_o, tag_o);

endinterface

// File: rtl/bsg_logic_rr_arb.sv
// rtl/bsg_logic_rr_arb.sv - combinational round-robin grant, searching from last_i+1 upward
module bsg_logic_rr_arb
  #(parameter int num_req_p     = 4,
    parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1)
   (input  logic [num_req_p-1:0]     reqs_i,
    input  logic                     ready_i,
    input  logic [lg_num_req_lp-1:0] last_i,
    output logic [num_req_p-1:0]     grant_o,
    output logic [lg_num_req_lp-1:0] grant_id_o);

  logic [lg_num_req_lp:0]   sum;
  logic [lg_num_req_lp-1:0] idx;
  logic                     found;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    // One spare bit keeps last_i+i exact before the modulo fold.
    for (int i = 1; i <= num_req_p; i++) begin
      sum = {1'b0, last_i} + (lg_num_req_lp+1)'(i);
      if (sum >= (lg_num_req_lp+1)'(num_req_p))
        sum = sum - (lg_num_req_lp+1)'(num_req_p);
      idx = sum[lg_num_req_lp-1:0];
      if (ready_i && !found && reqs_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_logic_rr_sched.sv
// rtl/bsg_logic_rr_sched.sv - round-robin share of one registered NOR/AND/OR/XOR unit
module bsg_logic_rr_sched
  import bsg_logic_pkg::*;
  #(parameter int width_p       = 16,
    parameter int num_req_p     = 4,
    parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1)
   (input logic                 clk_i,
    input logic                 reset_i,
    bsg_logic_rr_sched_if.slave io);

  logic                     ready;
  logic [num_req_p-1:0]     grant;
  logic [lg_num_req_lp-1:0] grant_id;
  logic [width_p-1:0]       a_sel, b_sel;
  bsg_logic_op_e            op_sel;
  logic [bsg_logic_max_width_gp-1:0] res_wide;

  logic                     v_q, v_d;
  logic [width_p-1:0]       data_q, data_d;
  logic [lg_num_req_lp-1:0] tag_q, tag_d;
  logic [lg_num_req_lp-1:0] last_q, last_d;

  assign ready = ~v_q | io.yumi_i;

  bsg_logic_rr_arb #(.num_req_p(num_req_p), .lg_num_req_lp(lg_num_req_lp)) arb
    (.reqs_i    (io.v_i),
     .ready_i   (ready & ~reset_i),
     .last_i    (last_q),
     .grant_o   (grant),
     .grant_id_o(grant_id));

  assign a_sel    = io.a_i[grant_id*width_p +: width_p];
  assign b_sel    = io.b_i[grant_id*width_p +: width_p];
  assign op_sel   = bsg_logic_op_e'(io.op_i[grant_id*2 +: 2]);
  assign res_wide = bsg_logic_apply(op_sel,
                                    bsg_logic_max_width_gp'(a_sel),
                                    bsg_logic_max_width_gp'(b_sel));

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    last_d = last_q;
    if (ready) begin
      v_d = |grant;
      if (|grant) begin
        data_d = res_wide[width_p-1:0];
        tag_d  = grant_id;
        last_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      last_q <= lg_num_req_lp'(num_req_p-1);
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      last_q <= last_d;
    end
  end

  assign io.yumi_o = grant;
  assign io.v_o    = v_q;
  assign io.data_o = data_q;
  assign io.tag_o  = tag_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.yumi_i && !v_q));
      assert ($onehot0(grant));
    end
  end
`endif

endmodule
